// File: rtl/qdec_pkg.sv
// Shared types for the quadrature step decoder: A/B state encoding and step classification.
package qdec_pkg;

  typedef logic [1:0] ab_t;

  localparam ab_t AB_00 = 2'b00;
  localparam ab_t AB_10 = 2'b10;
  localparam ab_t AB_11 = 2'b11;
  localparam ab_t AB_01 = 2'b01;

  typedef enum logic [1:0] {UP, DOWN, NONE, ILLEGAL} dir_t;

  // Forward rotation walks 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  function automatic ab_t next_fwd(input ab_t s);
    ab_t r;
    case (s)
      AB_00:   r = AB_10;
      AB_10:   r = AB_11;
      AB_11:   r = AB_01;
      default: r = AB_00;
    endcase
    return r;
  endfunction

  function automatic dir_t step_dir(input ab_t prev, input ab_t cur);
    dir_t r;
    if (prev == cur)
      r = NONE;
    else if ((prev ^ cur) == 2'b11)
      r = ILLEGAL;
    else if (next_fwd(prev) == cur)
      r = UP;
    else
      r = DOWN;
    return r;
  endfunction

endpackage

// File: rtl/qdec_in_cond.sv
// One encoder input channel: 2-FF synchronizer, plus a glitch filter when QDEC_FILTER_EN is defined.
module qdec_in_cond #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_valid
);

  logic r_sync1;
  logic r_sync2;
  logic r_fill1;
  logic r_fill2;

  // r_fill tracks when the synchronizer holds a real pin sample rather than its reset zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_fill1 <= 1'b0;
      r_fill2 <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_fill1 <= 1'b1;
      r_fill2 <= r_fill1;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int unsigned CntW = $clog2(FILT_LEN + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILT_LEN - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_level;
  logic            r_primed;

  // The first filled sample is taken as-is; afterwards a new level needs FILT_LEN equal samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_primed <= 1'b0;
    end else if (!r_primed) begin
      r_cnt <= '0;
      if (r_fill2) begin
        r_level  <= r_sync2;
        r_primed <= 1'b1;
      end
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CntLast) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;
  assign o_valid = r_primed;
`else
  assign o_level = r_sync2;
  assign o_valid = r_fill2;
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B + index decoder producing load/countup/countdown pulses for the up/down counter.
// Optional glitch filter on every input is enabled by defining QDEC_FILTER_EN.
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned HOME     = 0,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       idx_in,
  input  logic       clear,
  output logic       load,
  output logic [N:0] d,
  output logic       countup,
  output logic       countdown,
  output logic       err
);

  localparam logic [N:0] HomeVal = (N + 1)'(HOME);

  logic w_a;
  logic w_b;
  logic w_idx;
  logic w_aValid;
  logic w_bValid;
  logic w_idxValid;
  logic w_chValid;
  ab_t  w_cur;
  dir_t w_dir;
  logic w_idxRise;
  logic w_loadNext;
  logic w_upNext;
  logic w_downNext;
  logic w_errSet;

  ab_t  r_prev;
  logic r_idxPrev;
  logic r_valid;

  qdec_in_cond #(.FILT_LEN(FILT_LEN)) u_condA (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (a_in),
    .o_level (w_a),
    .o_valid (w_aValid)
  );

  qdec_in_cond #(.FILT_LEN(FILT_LEN)) u_condB (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (b_in),
    .o_level (w_b),
    .o_valid (w_bValid)
  );

  qdec_in_cond #(.FILT_LEN(FILT_LEN)) u_condIdx (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (idx_in),
    .o_level (w_idx),
    .o_valid (w_idxValid)
  );

  assign w_chValid = w_aValid & w_bValid & w_idxValid;
  assign w_cur     = {w_a, w_b};
  assign w_dir     = step_dir(r_prev, w_cur);
  assign w_idxRise = w_idx & ~r_idxPrev;
  assign d         = HomeVal;

  // A load in the same cycle as a step swallows the step; the counter reloads anyway.
  always_comb begin
    w_loadNext = 1'b0;
    w_upNext   = 1'b0;
    w_downNext = 1'b0;
    w_errSet   = 1'b0;
    if (r_valid) begin
      w_loadNext = w_idxRise;
      w_errSet   = (w_dir == ILLEGAL);
      if (!w_idxRise) begin
        w_upNext   = (w_dir == UP);
        w_downNext = (w_dir == DOWN);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load      <= 1'b0;
      countup   <= 1'b0;
      countdown <= 1'b0;
      err       <= 1'b0;
      r_prev    <= AB_00;
      r_idxPrev <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      load      <= w_loadNext;
      countup   <= w_upNext;
      countdown <= w_downNext;
      if (w_errSet)
        err <= 1'b1;
      else if (clear)
        err <= 1'b0;
      if (w_chValid) begin
        r_prev    <= w_cur;
        r_idxPrev <= w_idx;
        r_valid   <= 1'b1;
      end
    end
  end

endmodule
